// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared constants for the hazard scoreboard: tracked-stage indices, the
// "operand unused" Tuse code, Tnew codes for the instruction classes, and a
// default-width view of one scoreboard entry.
// -----------------------------------------------------------------------------
package hazard_pkg;

  // Stage indices after D: entry[STG_E] is the instruction currently in E.
  localparam int STG_E = 1;
  localparam int STG_M = 2;
  localparam int STG_W = 3;

  // Tuse code meaning the operand is not read at all.
  localparam logic [1:0] TUSE_NONE = 2'b11;

  // Tnew codes at E entry: cycles until the result is forwardable.
  localparam logic [1:0] TNEW_PC8  = 2'd0;  // jal link value, ready in E
  localparam logic [1:0] TNEW_ALU  = 2'd1;  // ALU result, ready from M
  localparam logic [1:0] TNEW_LOAD = 2'd2;  // load data, ready from W

  // One tracked entry at default widths (AW=5, TW=2).
  typedef struct packed {
    logic       v;
    logic [4:0] wa;
    logic [1:0] tnew;
  } hz_entry_t;

endpackage

// File: rtl/fwd_pick.sv
// -----------------------------------------------------------------------------
// fwd_pick
// Priority match of one source register against a contiguous run of tracked
// stages. Reports the youngest matching stage and that entry's Tnew; register
// 0 never matches.
// Ports:
//   i_v     [N]      valid bit per candidate stage (bit 0 = stage BASE)
//   i_wa    [N*AW]   destination register per candidate stage
//   i_tnew  [N*TW]   remaining Tnew per candidate stage
//   i_src   [AW]     source register being looked up
//   o_p     [SELW]   youngest matching stage index, 0 if none
//   o_tnew  [TW]     Tnew of that stage, 0 if none
// -----------------------------------------------------------------------------
module fwd_pick #(
  parameter int AW   = 5,
  parameter int TW   = 2,
  parameter int SELW = 2,
  parameter int N    = 3,
  parameter int BASE = 1
) (
  input  logic [N-1:0]    i_v,
  input  logic [N*AW-1:0] i_wa,
  input  logic [N*TW-1:0] i_tnew,
  input  logic [AW-1:0]   i_src,
  output logic [SELW-1:0] o_p,
  output logic [TW-1:0]   o_tnew
);

  // Walk from oldest to youngest so the youngest match overwrites older ones.
  always_comb begin
    o_p    = '0;
    o_tnew = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (i_v[k] && (i_wa[k*AW +: AW] == i_src) && (i_src != '0)) begin
        o_p    = SELW'(BASE + k);
        o_tnew = i_tnew[k*TW +: TW];
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
// Hazard unit for the pipelined MIPS core. Tracks each in-flight destination
// with its remaining Tnew, tracks mult/div occupancy, and produces the D-stage
// stall and forwarding selects for the D, E and M consumers.
// Ports:
//   clk, reset            clock; synchronous active-low reset
//   d_valid               D holds a real instruction
//   d_rs, d_rt            D source registers
//   d_tuse_rs, d_tuse_rt  cycles until D needs the operand (all-ones = unused)
//   d_wa, d_tnew          D destination register and its Tnew at E entry
//   d_md_start, d_md_div  D starts mult/div; div selects the long latency
//   d_md_use              D touches HI/LO or the md unit
//   flush                 squash all tracked E..W entries next edge
//   stall                 hold PC/D and insert a bubble into E
//   fwd_d, fwd_e          {rt,rs} forwarding selects (0 = regfile, p = stage)
//   fwd_m                 rt forwarding select for M (store data)
//   md_busy               md unit counter nonzero
// -----------------------------------------------------------------------------
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int AW       = 5,
  parameter int STAGES   = 3,
  parameter int TW       = 2,
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10,
  parameter int CW       = 4,
  localparam int SELW    = $clog2(STAGES + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              d_valid,
  input  logic [AW-1:0]     d_rs,
  input  logic [AW-1:0]     d_rt,
  input  logic [TW-1:0]     d_tuse_rs,
  input  logic [TW-1:0]     d_tuse_rt,
  input  logic [AW-1:0]     d_wa,
  input  logic [TW-1:0]     d_tnew,
  input  logic              d_md_start,
  input  logic              d_md_div,
  input  logic              d_md_use,
  input  logic              flush,
  output logic              stall,
  output logic [2*SELW-1:0] fwd_d,
  output logic [2*SELW-1:0] fwd_e,
  output logic [SELW-1:0]   fwd_m,
  output logic              md_busy
);

  // Tracked state. Only the E stage needs md/div and rs; only E and M need rt.
  logic [STAGES:1]         r_v;
  logic [STAGES:1][AW-1:0] r_wa;
  logic [STAGES:1][TW-1:0] r_tnew;
  logic                    r_e_md;
  logic                    r_e_div;
  logic [AW-1:0]           r_e_rs;
  logic [AW-1:0]           r_e_rt;
  logic [AW-1:0]           r_m_rt;
  logic [CW-1:0]           r_md_cnt;

  function automatic logic [TW-1:0] f_tnew_dec(input logic [TW-1:0] t);
    return (t == '0) ? t : t - TW'(1);
  endfunction

  // A youngest match that is not ready yet blocks forwarding from older stages.
  function automatic logic [SELW-1:0] f_sel(input logic [SELW-1:0] p,
                                            input logic [TW-1:0]   t);
    return (t == '0) ? p : '0;
  endfunction

  function automatic logic f_tuse_hz(input logic [TW-1:0] t,
                                     input logic [TW-1:0] tuse);
    return (tuse != '1) && (t > tuse);
  endfunction

  // ---- lookups: D sees all stages, E sees M and older, M sees W ----
  logic [SELW-1:0] w_p_drs, w_p_drt, w_p_ers, w_p_ert, w_p_mrt;
  logic [TW-1:0]   w_t_drs, w_t_drt, w_t_ers, w_t_ert, w_t_mrt;

  fwd_pick #(.AW(AW), .TW(TW), .SELW(SELW), .N(STAGES), .BASE(STG_E)) u_pick_drs (
    .i_v(r_v), .i_wa(r_wa), .i_tnew(r_tnew), .i_src(d_rs),
    .o_p(w_p_drs), .o_tnew(w_t_drs));
  fwd_pick #(.AW(AW), .TW(TW), .SELW(SELW), .N(STAGES), .BASE(STG_E)) u_pick_drt (
    .i_v(r_v), .i_wa(r_wa), .i_tnew(r_tnew), .i_src(d_rt),
    .o_p(w_p_drt), .o_tnew(w_t_drt));
  fwd_pick #(.AW(AW), .TW(TW), .SELW(SELW), .N(STAGES-STG_M+1), .BASE(STG_M)) u_pick_ers (
    .i_v(r_v[STAGES:STG_M]), .i_wa(r_wa[STAGES:STG_M]), .i_tnew(r_tnew[STAGES:STG_M]),
    .i_src(r_e_rs), .o_p(w_p_ers), .o_tnew(w_t_ers));
  fwd_pick #(.AW(AW), .TW(TW), .SELW(SELW), .N(STAGES-STG_M+1), .BASE(STG_M)) u_pick_ert (
    .i_v(r_v[STAGES:STG_M]), .i_wa(r_wa[STAGES:STG_M]), .i_tnew(r_tnew[STAGES:STG_M]),
    .i_src(r_e_rt), .o_p(w_p_ert), .o_tnew(w_t_ert));
  fwd_pick #(.AW(AW), .TW(TW), .SELW(SELW), .N(STAGES-STG_W+1), .BASE(STG_W)) u_pick_mrt (
    .i_v(r_v[STAGES:STG_W]), .i_wa(r_wa[STAGES:STG_W]), .i_tnew(r_tnew[STAGES:STG_W]),
    .i_src(r_m_rt), .o_p(w_p_mrt), .o_tnew(w_t_mrt));

  // ---- D stall: operand not ready in time, or md unit occupied ----
  logic w_md_in_e;
  logic w_stall;

  assign w_md_in_e = r_v[STG_E] && r_e_md;
  assign w_stall   = reset && d_valid &&
                     (f_tuse_hz(w_t_drs, d_tuse_rs) ||
                      f_tuse_hz(w_t_drt, d_tuse_rt) ||
                      (d_md_use && ((r_md_cnt != '0) || w_md_in_e)));

  // Outputs are forced quiet while reset is asserted.
  assign stall   = w_stall;
  assign fwd_d   = reset ? {f_sel(w_p_drt, w_t_drt), f_sel(w_p_drs, w_t_drs)} : '0;
  assign fwd_e   = reset ? {f_sel(w_p_ert, w_t_ert), f_sel(w_p_ers, w_t_ers)} : '0;
  assign fwd_m   = reset ? f_sel(w_p_mrt, w_t_mrt) : '0;
  assign md_busy = reset && (r_md_cnt != '0);

  // ---- D -> E insert and E..W advance: control ----
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_v      <= '0;
      r_md_cnt <= '0;
    end else begin
      r_v[STG_E] <= d_valid && !w_stall && !flush;
      for (int p = 2; p <= STAGES; p++) begin
        r_v[p] <= r_v[p-1] && !flush;
      end
      // Load is taken from the instruction in E even if it is being flushed.
      if (w_md_in_e) begin
        r_md_cnt <= r_e_div ? CW'(DIV_CYC) : CW'(MULT_CYC);
      end else if (r_md_cnt != '0) begin
        r_md_cnt <= r_md_cnt - CW'(1);
      end
    end
  end

  // ---- D -> E insert and E..W advance: data (qualified by r_v) ----
  always_ff @(posedge clk) begin
    r_wa[STG_E]   <= d_wa;
    r_tnew[STG_E] <= d_tnew;
    r_e_md        <= d_md_start;
    r_e_div       <= d_md_div;
    r_e_rs        <= d_rs;
    r_e_rt        <= d_rt;
    r_m_rt        <= r_e_rt;
    for (int p = 2; p <= STAGES; p++) begin
      r_wa[p]   <= r_wa[p-1];
      r_tnew[p] <= f_tnew_dec(r_tnew[p-1]);
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;
  import hazard_pkg::*;

  logic       clk;
  logic       reset;
  logic       d_valid;
  logic [4:0] d_rs, d_rt, d_wa;
  logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew;
  logic       d_md_start, d_md_div, d_md_use;
  logic       flush;
  logic       stall;
  logic [3:0] fwd_d, fwd_e;
  logic [1:0] fwd_m;
  logic       md_busy;

  int n_cmp;
  int n_fail;
  int n;
  int nb;

  hazard_scoreboard dut (
    .clk(clk), .reset(reset), .d_valid(d_valid), .d_rs(d_rs), .d_rt(d_rt),
    .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt), .d_wa(d_wa), .d_tnew(d_tnew),
    .d_md_start(d_md_start), .d_md_div(d_md_div), .d_md_use(d_md_use),
    .flush(flush), .stall(stall), .fwd_d(fwd_d), .fwd_e(fwd_e), .fwd_m(fwd_m),
    .md_busy(md_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    d_valid = 0; d_rs = 0; d_rt = 0; d_wa = 0; d_tnew = 0;
    d_tuse_rs = TUSE_NONE; d_tuse_rt = TUSE_NONE;
    d_md_start = 0; d_md_div = 0; d_md_use = 0; flush = 0;
  endtask

  task automatic set_d(input logic [4:0] rs, input logic [4:0] rt,
                       input logic [1:0] urs, input logic [1:0] urt,
                       input logic [4:0] wa, input logic [1:0] tn);
    d_valid = 1; d_rs = rs; d_rt = rt; d_tuse_rs = urs; d_tuse_rt = urt;
    d_wa = wa; d_tnew = tn; d_md_start = 0; d_md_div = 0; d_md_use = 0;
  endtask

  task automatic drain();
    idle();
    repeat (4) tick();
  endtask

  initial begin
    clk = 0; n_cmp = 0; n_fail = 0;
    reset = 0;
    idle();
    // mult sitting in D while reset is held
    set_d(5'd0, 5'd0, TUSE_NONE, TUSE_NONE, 5'd0, TNEW_ALU);
    d_md_start = 1; d_md_use = 1;
    tick(); tick();
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_busy", 32'(md_busy), 32'd0);
    check("rst_fwd_d", 32'(fwd_d), 32'd0);
    check("rst_fwd_e", 32'(fwd_e), 32'd0);
    check("rst_fwd_m", 32'(fwd_m), 32'd0);
    idle();
    reset = 1;
    tick();
    check("post_rst_stall", 32'(stall), 32'd0);
    check("post_rst_busy", 32'(md_busy), 32'd0);

    // addu $3 ; addu $4,$3,$3
    set_d(5'd1, 5'd2, 2'd1, 2'd1, 5'd3, TNEW_ALU); #1;
    check("A_first_stall", 32'(stall), 32'd0);
    tick();
    set_d(5'd3, 5'd3, 2'd1, 2'd1, 5'd4, TNEW_ALU); #1;
    check("A_dep_stall", 32'(stall), 32'd0);
    check("A_dep_fwd_d", 32'(fwd_d), 32'd0);
    tick();
    set_d(5'd3, 5'd0, 2'd0, TUSE_NONE, 5'd0, TNEW_ALU); #1;
    check("A_fwd_e", 32'(fwd_e), 32'b1010);
    check("A_fwd_d_M", 32'(fwd_d), 32'd2);
    check("A_late_stall", 32'(stall), 32'd0);
    drain();

    // lw $5 ; beq $5,$0
    set_d(5'd0, 5'd0, 2'd1, TUSE_NONE, 5'd5, TNEW_LOAD); #1;
    tick();
    set_d(5'd5, 5'd0, 2'd0, 2'd0, 5'd0, TNEW_ALU); #1;
    check("B_stall1", 32'(stall), 32'd1);
    check("B_fwd_d1", 32'(fwd_d), 32'd0);
    tick();
    check("B_stall2", 32'(stall), 32'd1);
    tick();
    check("B_stall3", 32'(stall), 32'd0);
    check("B_fwd_d3", 32'(fwd_d), 32'd3);
    drain();

    // jal ; jr $31
    set_d(5'd0, 5'd0, TUSE_NONE, TUSE_NONE, 5'd31, TNEW_PC8); #1;
    tick();
    set_d(5'd31, 5'd0, 2'd0, TUSE_NONE, 5'd0, TNEW_ALU); #1;
    check("C_stall", 32'(stall), 32'd0);
    check("C_fwd_d", 32'(fwd_d), 32'd1);
    drain();

    // ori $0 ; addu $6,$0,$0
    set_d(5'd0, 5'd0, 2'd1, TUSE_NONE, 5'd0, TNEW_ALU); #1;
    tick();
    set_d(5'd0, 5'd0, 2'd1, 2'd1, 5'd6, TNEW_ALU); #1;
    check("D_stall", 32'(stall), 32'd0);
    check("D_fwd_d", 32'(fwd_d), 32'd0);
    tick();
    idle(); #1;
    check("D_fwd_e", 32'(fwd_e), 32'd0);
    drain();

    // addu $11 ; lw $11 ; use $11 in E: youngest (load) wins and blocks older
    set_d(5'd0, 5'd0, 2'd1, TUSE_NONE, 5'd11, TNEW_ALU); #1;
    tick();
    set_d(5'd0, 5'd0, 2'd1, TUSE_NONE, 5'd11, TNEW_LOAD); #1;
    tick();
    set_d(5'd11, 5'd0, 2'd1, TUSE_NONE, 5'd12, TNEW_ALU); #1;
    check("E_stall", 32'(stall), 32'd1);
    check("E_fwd_d", 32'(fwd_d), 32'd0);
    drain();

    // lw $8 ; sw $8,0($0): store data forwarded into M
    set_d(5'd0, 5'd0, 2'd1, TUSE_NONE, 5'd8, TNEW_LOAD); #1;
    tick();
    set_d(5'd0, 5'd8, 2'd1, 2'd2, 5'd0, TNEW_ALU); #1;
    check("F_stall", 32'(stall), 32'd0);
    check("F_fwd_d", 32'(fwd_d), 32'd0);
    tick();
    idle(); #1;
    check("F_fwd_e", 32'(fwd_e), 32'd0);
    tick();
    check("F_fwd_m", 32'(fwd_m), 32'd3);
    drain();

    // mult ; mflo
    set_d(5'd0, 5'd0, TUSE_NONE, TUSE_NONE, 5'd0, TNEW_ALU);
    d_md_start = 1; d_md_use = 1; #1;
    check("G_mult_stall", 32'(stall), 32'd0);
    tick();
    set_d(5'd0, 5'd0, TUSE_NONE, TUSE_NONE, 5'd2, TNEW_ALU);
    d_md_use = 1; #1;
    check("G_busy_first", 32'(md_busy), 32'd0);
    n = 0; nb = 0;
    while (stall === 1'b1 && n < 40) begin
      n++;
      if (md_busy === 1'b1) nb++;
      tick();
    end
    check("G_stall_cycles", 32'(n), 32'd6);
    check("G_busy_cycles", 32'(nb), 32'd5);
    check("G_busy_end", 32'(md_busy), 32'd0);
    drain();

    // div ; mfhi
    set_d(5'd0, 5'd0, TUSE_NONE, TUSE_NONE, 5'd0, TNEW_ALU);
    d_md_start = 1; d_md_div = 1; d_md_use = 1; #1;
    tick();
    set_d(5'd0, 5'd0, TUSE_NONE, TUSE_NONE, 5'd2, TNEW_ALU);
    d_md_use = 1; #1;
    n = 0; nb = 0;
    while (stall === 1'b1 && n < 40) begin
      n++;
      if (md_busy === 1'b1) nb++;
      tick();
    end
    check("H_stall_cycles", 32'(n), 32'd11);
    check("H_busy_cycles", 32'(nb), 32'd10);
    drain();

    // lw $7 in E + flush, with addu $13 in D at the flush edge
    set_d(5'd0, 5'd0, 2'd1, TUSE_NONE, 5'd7, TNEW_LOAD); #1;
    tick();
    set_d(5'd0, 5'd0, 2'd1, TUSE_NONE, 5'd13, TNEW_ALU);
    flush = 1; #1;
    tick();
    flush = 0;
    set_d(5'd7, 5'd13, 2'd0, 2'd0, 5'd0, TNEW_ALU); #1;
    check("I_stall", 32'(stall), 32'd0);
    check("I_fwd_d", 32'(fwd_d), 32'd0);
    drain();

    // reset asserted mid-div
    set_d(5'd0, 5'd0, TUSE_NONE, TUSE_NONE, 5'd0, TNEW_ALU);
    d_md_start = 1; d_md_div = 1; d_md_use = 1; #1;
    tick();
    set_d(5'd0, 5'd0, TUSE_NONE, TUSE_NONE, 5'd2, TNEW_ALU);
    d_md_use = 1;
    tick(); tick(); tick();
    check("J_busy_mid", 32'(md_busy), 32'd1);
    check("J_stall_mid", 32'(stall), 32'd1);
    reset = 0; #1;
    check("J_stall_gated", 32'(stall), 32'd0);
    check("J_busy_gated", 32'(md_busy), 32'd0);
    tick();
    reset = 1; #1;
    check("J_busy_after", 32'(md_busy), 32'd0);
    check("J_stall_after", 32'(stall), 32'd0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
